// File: rtl/sysid_probe_master_if.sv
// Avalon-MM read-only master bus used by the system-ID probe.
// The master drives address/read; the slave stalls and returns data.
interface sysid_probe_master_if;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic        avm_readdatavalid;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdatavalid,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdatavalid,
        output avm_readdata
    );
endinterface

// File: rtl/sysid_probe_master.sv
// Reads the system ID (word 1) and timestamp (word 0) over Avalon-MM,
// retries on timeout, and reports whether both match the expected values.
module sysid_probe_master #(
    parameter logic [31:0] EXPECTED_ID    = 32'd1434032738,
    parameter logic [31:0] EXPECTED_TS    = 32'd0,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          MAX_RETRIES    = 3
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    sysid_probe_master_if.master        avm,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic                        id_ok,
    output logic                        ts_ok,
    output logic                        timeout_err,
    output logic [31:0]                 id_value,
    output logic [31:0]                 ts_value
);

    localparam logic [15:0] TMAX = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  RMAX = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        IDLE,
        ID_REQ,
        ID_WAIT,
        TS_REQ,
        TS_WAIT,
        CHECK,
        FINISH
    } state_t;

    state_t      state;
    logic [15:0] tcnt;
    logic [3:0]  retries;

    logic is_id;
    logic is_req;
    logic expired;
    logic can_retry;

    assign is_id     = (state == ID_REQ) || (state == ID_WAIT);
    assign is_req    = (state == ID_REQ) || (state == TS_REQ);
    assign expired   = (tcnt == TMAX);
    assign can_retry = (retries < RMAX);

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            tcnt            <= '0;
            retries         <= '0;
            avm.avm_read    <= 1'b0;
            avm.avm_address <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            id_ok           <= 1'b0;
            ts_ok           <= 1'b0;
            timeout_err     <= 1'b0;
            id_value        <= '0;
            ts_value        <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state           <= ID_REQ;
                        busy            <= 1'b1;
                        pass            <= 1'b0;
                        id_ok           <= 1'b0;
                        ts_ok           <= 1'b0;
                        timeout_err     <= 1'b0;
                        retries         <= '0;
                        tcnt            <= '0;
                        avm.avm_read    <= 1'b1;
                        avm.avm_address <= 1'b1;
                    end
                end
                ID_REQ, ID_WAIT, TS_REQ, TS_WAIT: begin
                    tcnt <= tcnt + 16'd1;
                    // Any response counts, including a late one from a read
                    // issued before the latest retry.
                    if (avm.avm_readdatavalid) begin
                        if (is_id) begin
                            id_value        <= avm.avm_readdata;
                            state           <= TS_REQ;
                            tcnt            <= '0;
                            avm.avm_read    <= 1'b1;
                            avm.avm_address <= 1'b0;
                        end else begin
                            ts_value     <= avm.avm_readdata;
                            state        <= CHECK;
                            avm.avm_read <= 1'b0;
                        end
                    end else if (expired) begin
                        if (can_retry) begin
                            retries      <= retries + 4'd1;
                            tcnt         <= '0;
                            avm.avm_read <= 1'b1;
                            state        <= is_id ? ID_REQ : TS_REQ;
                        end else begin
                            timeout_err  <= 1'b1;
                            avm.avm_read <= 1'b0;
                            done         <= 1'b1;
                            state        <= FINISH;
                        end
                    end else if (is_req && !avm.avm_waitrequest) begin
                        avm.avm_read <= 1'b0;
                        state        <= is_id ? ID_WAIT : TS_WAIT;
                    end
                end
                CHECK: begin
                    id_ok <= (id_value == EXPECTED_ID);
                    ts_ok <= (ts_value == EXPECTED_TS);
                    pass  <= (id_value == EXPECTED_ID) &&
                             (ts_value == EXPECTED_TS);
                    done  <= 1'b1;
                    state <= FINISH;
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_probe_master.sv
// Bench for sysid_probe_master: configurable Avalon slave model plus
// a second instance with a short timeout for the retry/abort path.
module tb_sysid_probe_master;

    localparam logic [31:0] EXP_ID = 32'd1434032738;
    localparam logic [31:0] EXP_TS = 32'd0;
    localparam int T2 = 8;
    localparam int R2 = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic start2 = 1'b0;

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    sysid_probe_master_if bus ();
    sysid_probe_master_if bus2 ();

    logic busy, done, pass, id_ok, ts_ok, timeout_err;
    logic [31:0] id_value, ts_value;
    logic busy2, done2, pass2, id_ok2, ts_ok2, timeout_err2;
    logic [31:0] id_value2, ts_value2;

    sysid_probe_master dut (
        .clock(clock), .reset(reset), .start(start), .avm(bus),
        .busy(busy), .done(done), .pass(pass), .id_ok(id_ok),
        .ts_ok(ts_ok), .timeout_err(timeout_err),
        .id_value(id_value), .ts_value(ts_value)
    );

    sysid_probe_master #(.TIMEOUT_CYCLES(T2), .MAX_RETRIES(R2)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .avm(bus2),
        .busy(busy2), .done(done2), .pass(pass2), .id_ok(id_ok2),
        .ts_ok(ts_ok2), .timeout_err(timeout_err2),
        .id_value(id_value2), .ts_value(ts_value2)
    );

    // Slave model: stalls wait_cycles per read, answers rsp_delay cycles
    // after acceptance (0 = same cycle).
    int wait_cycles = 0;
    int rsp_delay = 0;
    logic [31:0] id_data = EXP_ID;
    logic [31:0] ts_data = EXP_TS;
    int stall_cnt = 0;
    logic pend_valid = 1'b0;
    int pend_cnt = 0;
    logic pend_addr = 1'b0;
    logic accept, pend_fire, rsp_addr;

    assign bus.avm_waitrequest = bus.avm_read && (stall_cnt < wait_cycles);
    assign accept = bus.avm_read && !bus.avm_waitrequest;
    assign pend_fire = pend_valid && (pend_cnt == 0);
    assign bus.avm_readdatavalid = (accept && rsp_delay == 0) || pend_fire;
    assign rsp_addr = pend_fire ? pend_addr : bus.avm_address;
    assign bus.avm_readdata = rsp_addr ? id_data : ts_data;

    always_ff @(posedge clock) begin
        if (pend_valid) begin
            if (pend_cnt == 0) pend_valid <= 1'b0;
            else pend_cnt <= pend_cnt - 1;
        end
        if (bus.avm_read && bus.avm_waitrequest) stall_cnt <= stall_cnt + 1;
        if (accept) begin
            stall_cnt <= 0;
            if (rsp_delay > 0) begin
                pend_valid <= 1'b1;
                pend_cnt   <= rsp_delay - 1;
                pend_addr  <= bus.avm_address;
            end
        end
    end

    // Second slave never answers.
    assign bus2.avm_waitrequest   = 1'b0;
    assign bus2.avm_readdatavalid = 1'b0;
    assign bus2.avm_readdata      = EXP_ID;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(input int lim, inout int lat);
        while (!done && lat < lim) begin
            tick();
            lat++;
        end
    endtask

    // Start one sequence; lat counts cycles from the start-sampling edge.
    task automatic launch(output int lat);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        total++;
        if ({busy, done, pass, id_ok, ts_ok, timeout_err, bus.avm_read,
             bus.avm_address, id_value, ts_value} !== 72'd0) begin
            bad++;
            $display("FAIL reset_state got busy=%b done=%b pass=%b rd=%b id=%h want all 0",
                     busy, done, pass, bus.avm_read, id_value);
        end
        total++;
        if ({busy2, done2, bus2.avm_read, timeout_err2} !== 4'd0) begin
            bad++;
            $display("FAIL reset_state2 got busy=%b rd=%b want 0", busy2, bus2.avm_read);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_nominal;
        int lat;
        wait_cycles = 0; rsp_delay = 0; id_data = EXP_ID; ts_data = EXP_TS;
        launch(lat);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL nominal_busy got=%b want=1", busy);
        end
        wait_done(100, lat);
        total++;
        if (done !== 1'b1 || lat != 4) begin
            bad++;
            $display("FAIL nominal_latency got done=%b lat=%0d want done=1 lat=4", done, lat);
        end
        total++;
        if ({pass, id_ok, ts_ok, timeout_err} !== 4'b1110 || id_value !== EXP_ID) begin
            bad++;
            $display("FAIL nominal_result got flags=%b%b%b%b id=%h want 1110 id=%h",
                     pass, id_ok, ts_ok, timeout_err, id_value, EXP_ID);
        end
        tick(); tick(); tick();
        total++;
        if ({done, busy, pass} !== 3'b001 || id_value !== EXP_ID) begin
            bad++;
            $display("FAIL nominal_hold got done=%b busy=%b pass=%b want 0 0 1", done, busy, pass);
        end
    endtask

    task automatic test_bad_id;
        int lat;
        wait_cycles = 0; rsp_delay = 0; id_data = 32'h12345678; ts_data = EXP_TS;
        launch(lat);
        wait_done(100, lat);
        total++;
        if (done !== 1'b1 || {pass, id_ok, ts_ok} !== 3'b001 || id_value !== 32'h12345678) begin
            bad++;
            $display("FAIL bad_id got done=%b flags=%b%b%b id=%h want 1 001 12345678",
                     done, pass, id_ok, ts_ok, id_value);
        end
        tick();
    endtask

    task automatic test_stall;
        int lat;
        int unstable;
        wait_cycles = 5; rsp_delay = 3; id_data = EXP_ID; ts_data = EXP_TS;
        unstable = 0;
        launch(lat);
        for (int i = 0; i < 5; i++) begin
            if (!(bus.avm_read === 1'b1 && bus.avm_address === 1'b1 &&
                  bus.avm_waitrequest === 1'b1)) unstable++;
            tick();
            lat++;
        end
        total++;
        if (unstable != 0 || bus.avm_read !== 1'b1 || bus.avm_address !== 1'b1) begin
            bad++;
            $display("FAIL stall_stable got bad_cycles=%0d rd=%b addr=%b want 0 1 1",
                     unstable, bus.avm_read, bus.avm_address);
        end
        tick();
        lat++;
        total++;
        if (bus.avm_read !== 1'b0) begin
            bad++;
            $display("FAIL stall_read_drop got=%b want=0", bus.avm_read);
        end
        wait_done(200, lat);
        total++;
        if (done !== 1'b1 || pass !== 1'b1 || lat != 2 * (5 + 1 + 3) + 2) begin
            bad++;
            $display("FAIL stall_result got done=%b pass=%b lat=%0d want 1 1 %0d",
                     done, pass, lat, 2 * (5 + 1 + 3) + 2);
        end
        tick();
        wait_cycles = 0; rsp_delay = 0;
    endtask

    task automatic test_timeout;
        int lat;
        int issues;
        int ndone;
        issues = 0;
        ndone = 0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        lat = 1;
        while (!done2 && lat < 200) begin
            if (bus2.avm_read && bus2.avm_address) issues++;
            tick();
            lat++;
        end
        total++;
        if (done2 !== 1'b1 || lat != (R2 + 1) * T2 + 1) begin
            bad++;
            $display("FAIL timeout_latency got done=%b lat=%0d want 1 %0d",
                     done2, lat, (R2 + 1) * T2 + 1);
        end
        total++;
        if (issues != R2 + 1) begin
            bad++;
            $display("FAIL timeout_issues got=%0d want=%0d", issues, R2 + 1);
        end
        total++;
        if ({timeout_err2, pass2} !== 2'b10) begin
            bad++;
            $display("FAIL timeout_flags got err=%b pass=%b want 1 0", timeout_err2, pass2);
        end
        for (int i = 0; i < 10; i++) begin
            if (done2) ndone++;
            tick();
        end
        total++;
        if (ndone != 1 || busy2 !== 1'b0) begin
            bad++;
            $display("FAIL timeout_single_done got=%0d busy=%b want 1 0", ndone, busy2);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        int ndone;
        int lat;
        wait_cycles = 0; rsp_delay = 5; id_data = EXP_ID; ts_data = EXP_TS;
        n = 0;
        ndone = 0;
        launch(lat);
        while (!(busy && !bus.avm_read && !bus.avm_address) && n < 50) begin
            tick();
            n++;
        end
        total++;
        if (!(busy === 1'b1 && bus.avm_read === 1'b0 && bus.avm_address === 1'b0)) begin
            bad++;
            $display("FAIL reset_mid_reach got busy=%b rd=%b want in ts wait", busy, bus.avm_read);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if ({busy, done, pass, id_ok, ts_ok, timeout_err, bus.avm_read,
             bus.avm_address, id_value, ts_value} !== 72'd0) begin
            bad++;
            $display("FAIL reset_mid_state got busy=%b done=%b id=%h want all 0",
                     busy, done, id_value);
        end
        for (int i = 0; i < 10; i++) begin
            if (done || busy) ndone++;
            tick();
        end
        total++;
        if (ndone != 0) begin
            bad++;
            $display("FAIL reset_mid_quiet got=%0d want=0", ndone);
        end
        rsp_delay = 0;
        launch(lat);
        wait_done(100, lat);
        total++;
        if (done !== 1'b1 || pass !== 1'b1 || lat != 4) begin
            bad++;
            $display("FAIL reset_mid_rerun got done=%b pass=%b lat=%0d want 1 1 4", done, pass, lat);
        end
        tick();
    endtask

    task automatic test_start_while_busy;
        int ndone;
        wait_cycles = 1; rsp_delay = 1; id_data = EXP_ID; ts_data = EXP_TS;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            start = (i == 0 || i == 3 || i == 5 || i == 8);
            tick();
            if (done) ndone++;
        end
        start = 1'b0;
        total++;
        if (ndone != 1 || busy !== 1'b0 || pass !== 1'b1) begin
            bad++;
            $display("FAIL busy_start got dones=%0d busy=%b pass=%b want 1 0 1", ndone, busy, pass);
        end
        wait_cycles = 0; rsp_delay = 0;
    endtask

    task automatic test_random;
        int lat;
        int exp_lat;
        logic e_id, e_ts;
        for (int k = 0; k < 16; k++) begin
            wait_cycles = int'($urandom_range(0, 3));
            rsp_delay   = int'($urandom_range(0, 3));
            id_data = $urandom_range(0, 1) ? EXP_ID : $urandom;
            ts_data = $urandom_range(0, 1) ? EXP_TS : $urandom;
            e_id = (id_data == EXP_ID);
            e_ts = (ts_data == EXP_TS);
            exp_lat = 2 * (wait_cycles + 1 + rsp_delay) + 2;
            launch(lat);
            wait_done(200, lat);
            total++;
            if (done !== 1'b1 || lat != exp_lat) begin
                bad++;
                $display("FAIL rand_latency[%0d] got done=%b lat=%0d want 1 %0d",
                         k, done, lat, exp_lat);
            end
            total++;
            if ({pass, id_ok, ts_ok, timeout_err} !== {e_id & e_ts, e_id, e_ts, 1'b0} ||
                id_value !== id_data || ts_value !== ts_data) begin
                bad++;
                $display("FAIL rand_result[%0d] got flags=%b%b%b%b id=%h ts=%h want %b%b%b0 %h %h",
                         k, pass, id_ok, ts_ok, timeout_err, id_value, ts_value,
                         e_id & e_ts, e_id, e_ts, id_data, ts_data);
            end
            tick();
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL rand_pulse[%0d] got done=%b busy=%b want 0 0", k, done, busy);
            end
        end
        wait_cycles = 0; rsp_delay = 0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_bad_id();
        test_stall();
        test_timeout();
        test_reset_mid();
        test_start_while_busy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
